multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives all datapath strobes and muxes: PC, IR, register file, ALU, memory.
- Accepts a memory ready handshake and holds the FSM in memory states until the access completes.
- Supplies the JR path to the PC-source mux, replacing the single-cycle JR decode.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_en  out  1  PC load enable, equal to pc_write | (pc_write_cond & zero).
- pc_write_cond  out  1  branch-conditional PC write.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  register write-data select: 1 = MDR.
- reg_dst  out  1  destination select: 1 = rd, 0 = rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- alu_op  out  2  ALU op: 00 = add, 01 = sub, 10 = per funct.
- pc_source  out  2  next PC: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = register rs.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state_o  out  4  current state, for debug.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- State encoding:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5.
  - EXECUTE = 6, ALU_WB = 7, BRANCH = 8, JUMP = 9, ADDI_EXEC = 10, ADDI_WB = 11, JR = 12.
  - Codes 13-15 are unused; if reached, go to FETCH on the next clock.
- Reset: state = FETCH, retired = 0.
  - While reset is high, all strobes are forced to 0: pc_en, pc_write_cond, ir_write, reg_write, mem_read, mem_write, illegal_op.
  - Reset asserted mid-instruction aborts the instruction; no count is taken.
- Output timing: outputs are combinational from state, plus mem_ready/zero where noted. Unlisted outputs are 0 in every state.
- FETCH:
  - mem_read = 1, i_or_d = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - If mem_ready: ir_write = 1, pc_write = 1, go to DECODE. Otherwise stay, with ir_write = 0 and pc_write = 0.
- DECODE: alu_src_b = 11, alu_op = 00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR.
  - 000000 -> EXECUTE (or JR, see Optional Feature).
  - 000100 (beq) -> BRANCH.
  - 000010 (j) -> JUMP.
  - 001000 (addi) -> ADDI_EXEC.
  - Any other opcode -> illegal_op = 1, go to FETCH, no retire.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Go to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read = 1, i_or_d = 1. Stay until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Go to FETCH and retire.
- MEM_WRITE: mem_write = 1, i_or_d = 1. Stay until mem_ready, then go to FETCH and retire.
- EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Go to ALU_WB.
- ALU_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Go to FETCH and retire.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01. pc_en follows zero. Go to FETCH and retire.
- JUMP: pc_write = 1, pc_source = 10. Go to FETCH and retire.
- ADDI_EXEC: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Go to ADDI_WB.
- ADDI_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Go to FETCH and retire.
- Retire: retired increments by 1 on the clock edge leaving a completion state. It wraps modulo 2^CNT_W.
- Latency in clocks, with mem_ready tied high:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each cycle mem_ready is low adds one cycle in FETCH, MEM_READ or MEM_WRITE.

Optional Feature:
- Macro: MULTICYCLE_JR_EN.
- Defined: in DECODE, opcode 000000 with funct 001000 goes to JR.
  - JR: pc_write = 1, pc_source = 11. Go to FETCH and retire. Latency 3.
- Undefined: JR is never entered; that instruction takes the normal R-type path through EXECUTE and ALU_WB.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state localparams;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - FUNCT_JR;
  - ALUOp codes and pc_source codes.
- One sub-module, ctrl_out_decode: combinational state/mem_ready -> strobe decoder. The FSM register and retire counter stay in the top level.

Test Plan:
- Reset: hold reset high 3 clocks during MEM_READ, then release -> state_o = 0, retired = 0, all strobes 0 during reset.
- lw, mem_ready = 1:
  - state sequence 0, 1, 2, 3, 4, 0.
  - reg_write = 1 with mem_to_reg = 1 only in state 4.
  - retired 0 -> 1.
- sw with mem_ready low 2 cycles in MEM_WRITE: mem_write high 3 cycles, 6 clocks total, no reg_write.
- beq:
  - zero = 1 -> pc_en = 1 in BRANCH with pc_source = 01.
  - zero = 0 -> pc_en = 0.
  - Both retire.
- Opcode 111111: illegal_op pulses in DECODE, returns to FETCH, retired unchanged.
- R-type funct 001000:
  - With MULTICYCLE_JR_EN -> states 0, 1, 12, 0 and pc_source = 11.
  - Without -> states 0, 1, 6, 7, 0 and reg_write in 7.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state codes,
// opcode/funct constants, mux select codes and the decoded control bundle.
package mips_ctrl_pkg;

   // FSM state codes; 13..15 are unused and recover to S_FETCH
   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EXEC = 4'd10,
      S_ADDI_WB   = 4'd11,
      S_JR        = 4'd12
   } state_e;

   // Opcodes (IR[31:26]) and the JR function code (IR[5:0])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] FUNCT_JR = 6'b001000;

   // ALU operation select
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALU B operand select
   localparam logic [1:0] ALUB_B      = 2'b00;
   localparam logic [1:0] ALUB_FOUR   = 2'b01;
   localparam logic [1:0] ALUB_IMM    = 2'b10;
   localparam logic [1:0] ALUB_IMM_SH = 2'b11;

   // Next-PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_RS     = 2'b11;

   // Everything the datapath needs from the controller for one cycle
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal_op;
   } ctrl_t;

   // True for every opcode DECODE knows how to dispatch
   function automatic logic op_supported(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
   endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational strobe decoder: maps the current FSM state (plus mem_ready
// in FETCH and the opcode in DECODE) onto the datapath control bundle.
// Every field not set for a state stays 0.
module ctrl_out_decode
   import mips_ctrl_pkg::*;
(
   input  state_e      state,
   input  logic [5:0]  opcode,
   input  logic        mem_ready,
   output ctrl_t       ctrl
);

   // Per-state control values; zero defaults cover unlisted outputs
   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.i_or_d    = 1'b0;
            ctrl.alu_src_b = ALUB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_source = PCSRC_ALU;
            // IR and PC only load once the instruction word has arrived
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b  = ALUB_IMM_SH;
            ctrl.alu_op     = ALUOP_ADD;
            ctrl.illegal_op = !op_supported(opcode);
         end
         S_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEM_READ: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_dst    = 1'b0;
         end
         S_MEM_WRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_B;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_ALU_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.mem_to_reg = 1'b0;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = ALUB_B;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
         S_ADDI_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_ADDI_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b0;
            ctrl.mem_to_reg = 1'b0;
         end
         S_JR: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_RS;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath. Holds the state
// register and the retired-instruction counter; strobes come from
// ctrl_out_decode and are forced low while reset is asserted.
// Build option: define MULTICYCLE_JR_EN to route R-type funct JR through the
// dedicated JR state (PC <- rs); otherwise JR runs the normal R-type path.
module multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             pc_write_cond,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic             illegal_op,
   output logic [3:0]       state_o,
   output logic [CNT_W-1:0] retired
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             retire;
   logic             is_jr;
   ctrl_t            ctrl;

   // R-type with the JR function code
`ifdef MULTICYCLE_JR_EN
   assign is_jr = (funct == FUNCT_JR);
`else
   // funct is only consulted by the JR path
   logic unused_funct;
   assign unused_funct = ^funct;
   assign is_jr        = 1'b0;
`endif

   // Next-state selection and completion detection
   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_FETCH:     if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_RTYPE:     state_d = is_jr ? S_JR : S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDI_EXEC;
               default:      state_d = S_FETCH;   // illegal: dropped, not retired
            endcase
         end
         S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WRITE: begin
            if (mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXECUTE:   state_d = S_ALU_WB;
         S_ADDI_EXEC: state_d = S_ADDI_WB;
         S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB, S_JR: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         default:     state_d = S_FETCH;   // unused codes recover
      endcase
      retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
   end

   // State and retire counter; reset aborts any instruction in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   ctrl_out_decode u_dec (
      .state     (state_q),
      .opcode    (opcode),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   // Strobes are gated by reset so nothing fires while state is unknown/aborting
   assign pc_en         = !reset && (ctrl.pc_write || (ctrl.pc_write_cond && zero));
   assign pc_write_cond = !reset && ctrl.pc_write_cond;
   assign ir_write      = !reset && ctrl.ir_write;
   assign reg_write     = !reset && ctrl.reg_write;
   assign mem_read      = !reset && ctrl.mem_read;
   assign mem_write     = !reset && ctrl.mem_write;
   assign illegal_op    = !reset && ctrl.illegal_op;

   // Mux selects pass straight through
   assign i_or_d     = ctrl.i_or_d;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign reg_dst    = ctrl.reg_dst;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign alu_op     = ctrl.alu_op;
   assign pc_source  = ctrl.pc_source;

   assign state_o = state_q;
   assign retired = retired_q;

endmodule
